// File: rtl/piso_tx.sv
// Framed parallel-in serial-out transmitter: start bit, WIDTH data bits LSB first,
// optional even parity bit (enabled by defining PISO_TX_PARITY_EN), stop bit.
module piso_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_serial,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PISO_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  logic [CW-1:0]    tick;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] shift_reg;
`ifdef PISO_TX_PARITY_EN
  logic             parity_q;
`endif

  logic tick_last;
  logic bit_last;

  assign tick_last = (tick == CW'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_idx == IW'(WIDTH - 1));

  // tx_serial is updated on each bit boundary so the line is a clean registered output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick      <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef PISO_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_ready  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tick    <= '0;
          bit_idx <= '0;
          if (tx_valid && tx_ready) begin
            shift_reg <= tx_data;
`ifdef PISO_TX_PARITY_EN
            parity_q  <= ^tx_data;
`endif
            state     <= START;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
            tx_ready  <= 1'b0;
          end else begin
            tx_serial <= 1'b1;
            tx_ready  <= 1'b1;
          end
        end

        START: begin
          if (tick_last) begin
            tick      <= '0;
            bit_idx   <= '0;
            state     <= DATA;
            tx_serial <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end else begin
            tick <= tick + CW'(1);
          end
        end

        DATA: begin
          if (tick_last) begin
            tick <= '0;
            if (bit_last) begin
`ifdef PISO_TX_PARITY_EN
              state     <= PARITY;
              tx_serial <= parity_q;
`else
              state     <= STOP;
              tx_serial <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + IW'(1);
              tx_serial <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            tick <= tick + CW'(1);
          end
        end

`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          if (tick_last) begin
            tick      <= '0;
            state     <= STOP;
            tx_serial <= 1'b1;
          end else begin
            tick <= tick + CW'(1);
          end
        end
`endif

        STOP: begin
          if (tick_last) begin
            tick      <= '0;
            state     <= IDLE;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b1;
          end else begin
            tick <= tick + CW'(1);
          end
        end

        default: begin
          state     <= IDLE;
          tick      <= '0;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
          tx_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: per-cycle line comparison against a frame model
// built from the framing rules (honours PISO_TX_PARITY_EN).
module tb_piso_tx;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int NBITS = WIDTH + 3;
`else
  localparam int NBITS = WIDTH + 2;
`endif
  localparam int FRAME_CYCLES = NBITS * CPB;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic             tx_serial;
  logic             tx_busy;
  logic             tx_done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  piso_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected line level for every cycle of a frame, starting the cycle after accept
  function automatic void build_frame(input logic [WIDTH-1:0] d);
    bit p;
    exp_q.delete();
    p = 1'b0;
    for (int c = 0; c < CPB; c++) exp_q.push_back(1'b0);
    for (int b = 0; b < WIDTH; b++) begin
      p = p ^ d[b];
      for (int c = 0; c < CPB; c++) exp_q.push_back(d[b]);
    end
`ifdef PISO_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) exp_q.push_back(p);
`endif
    for (int c = 0; c < CPB; c++) exp_q.push_back(1'b1);
  endfunction

  task automatic do_frame(input logic [WIDTH-1:0] d, input bit keep_valid,
                          input logic [WIDTH-1:0] next_data, input int pulse_at,
                          input int abort_at);
    int n;
    build_frame(d);
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout data=%h: tx_ready=%b, required 1", d, tx_ready);
        tx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    tx_valid = keep_valid;
    tx_data  = next_data;
    for (int i = 0; i < FRAME_CYCLES; i++) begin
      @(negedge clk);
      checks++;
      if (tx_serial !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL line data=%h cycle=%0d: tx_serial=%b, required %b",
                 d, i, tx_serial, exp_q[i]);
      end
      checks++;
      if ({tx_busy, tx_ready, tx_done} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL in_frame_flags data=%h cycle=%0d: busy/ready/done=%b, required 100",
                 d, i, {tx_busy, tx_ready, tx_done});
      end
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        checks++;
        if ({tx_serial, tx_busy, tx_ready, tx_done} !== 4'b1000) begin
          errors++;
          $display("[TB] FAIL async_abort: serial/busy/ready/done=%b, required 1000",
                   {tx_serial, tx_busy, tx_ready, tx_done});
        end
        return;
      end
      if (i == pulse_at) begin
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
      end
      if (pulse_at >= 0 && i == pulse_at + 1) tx_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({tx_serial, tx_busy, tx_ready, tx_done} !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL done_edge data=%h: serial/busy/ready/done=%b, required 1011",
               d, {tx_serial, tx_busy, tx_ready, tx_done});
    end
  endtask

  task automatic check_idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_serial, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
        errors++;
        $display("[TB] FAIL idle_%s cycle=%0d: serial/busy/ready/done=%b, required 1010",
                 tag, i, {tx_serial, tx_busy, tx_ready, tx_done});
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_serial, tx_busy, tx_ready, tx_done} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_state: serial/busy/ready/done=%b, required 1000",
               {tx_serial, tx_busy, tx_ready, tx_done});
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: tx_ready=%b, required 0", tx_ready);
    end
    @(negedge clk);
    checks++;
    if ({tx_serial, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL ready_after_release: serial/busy/ready/done=%b, required 1010",
               {tx_serial, tx_busy, tx_ready, tx_done});
    end
  endtask

  task automatic test_frame_a5;
    do_frame(8'hA5, 1'b0, 8'h00, -1, -1);
    check_idle(2, "after_a5");
  endtask

  task automatic test_parity_word;
    do_frame(8'h07, 1'b0, 8'hFF, -1, -1);
    check_idle(2, "after_07");
  endtask

  task automatic test_back_to_back;
    do_frame(8'h00, 1'b1, 8'hFF, -1, -1);
    do_frame(8'hFF, 1'b0, 8'h00, -1, -1);
    check_idle(2, "after_b2b");
  endtask

  task automatic test_ignore_valid;
    do_frame(8'h81, 1'b0, 8'h81, 10, -1);
    check_idle(2 * FRAME_CYCLES, "after_ignore");
  endtask

  task automatic test_reset_midframe;
    do_frame(8'hF0, 1'b0, 8'hF0, -1, CPB * 4 + 1);
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_serial, tx_busy, tx_ready, tx_done} !== 4'b1000) begin
        errors++;
        $display("[TB] FAIL held_reset cycle=%0d: serial/busy/ready/done=%b, required 1000",
                 i, {tx_serial, tx_busy, tx_ready, tx_done});
      end
    end
    rst = 1'b1;
    check_idle(1, "after_abort");
    do_frame(8'h55, 1'b0, 8'h00, -1, -1);
    check_idle(2, "after_55");
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] junk;
    for (int k = 0; k < 6; k++) begin
      d    = WIDTH'($urandom);
      junk = WIDTH'($urandom);
      do_frame(d, 1'b0, junk, -1, -1);
      check_idle(1 + int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_parity_word();
    test_back_to_back();
    test_ignore_valid();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
